multicycle_controller: RTL and testbench

Sequencing controller for the multicycle RV32I datapath, the next step after the single-cycle core. It replaces the single-cycle combinational control decode with a Moore-style FSM. One shared memory, one ALU and the existing register file are reused across several cycles per instruction. It drives every datapath enable and mux select, and stalls on a memory-ready handshake.

---
 rtl/mc_pkg.sv | 86 ++++++++
 rtl/alu_decoder.sv | 39 +++
 rtl/multicycle_controller.sv | 176 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mc_pkg
//  Purpose  : Shared types and encodings for the multicycle RV32I controller:
//             FSM state enum, opcodes, datapath mux/ALU/immediate encodings.
//  Revision : 1.0  initial release
// ============================================================================
package mc_pkg;

  // Controller sequencing states
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_LUIWB    = 4'd11
  } state_e;

  // Supported opcodes
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // ALUControl encodings
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // ALUOp: what the ALU decoder is asked to produce
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ResultSrc encodings
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] RES_IMMEXT    = 2'b11;

  // ALUSrcA encodings
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  // ALUSrcB encodings
  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // ImmSrc encodings
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // Immediate format depends only on the opcode, independent of FSM state
  function automatic logic [2:0] imm_src_of(input logic [6:0] op);
    logic [2:0] imm;
    imm = IMM_I;
    case (op)
      OP_LOAD, OP_ITYPE: imm = IMM_I;
      OP_STORE:          imm = IMM_S;
      OP_BRANCH:         imm = IMM_B;
      OP_JAL:            imm = IMM_J;
      OP_LUI:            imm = IMM_U;
      default:           imm = 3'b000;
    endcase
    return imm;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : alu_decoder
//  Purpose  : Combinational ALUControl decode from ALUOp and instruction
//             function fields.
//  Revision : 1.0  initial release
// ============================================================================
module alu_decoder
  import mc_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic       op5,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [2:0] alu_control
);

  // Fixed add/sub for sequencing steps, function-field decode for execute
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // Only register-register forms with funct7[5] select subtract;
          // addi ignores funct7 since those bits belong to its immediate.
          3'b000:  alu_control = (op5 && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_controller
//  Purpose  : Moore-style sequencing FSM for the multicycle RV32I datapath.
//             Drives all datapath enables/selects, stalls on MemReady.
//  Revision : 1.0  initial release
// ============================================================================
module multicycle_controller
  import mc_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [2:0] ImmSrc,
  output logic       RegWrite,
  output logic       Illegal
);

  state_e     state_q, state_d;
  logic       pc_write, mem_read, mem_write, ir_write, reg_write, illegal;
  logic [1:0] alu_op;

  // Only funct7[5] participates in decode; the rest are intentionally unused
  logic unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  // State register; reset abandons any instruction in flight
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state and per-state datapath controls
  always_comb begin
    state_d   = state_q;
    pc_write  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    illegal   = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RD2;
    alu_op    = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        if (MemReady) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        // Precompute the branch/jump target into ALUOut
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_LUI:            state_d = S_LUIWB;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc    = 1'b1;
        ResultSrc = RES_ALUOUT;
        mem_read  = 1'b1;
        if (MemReady) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc    = 1'b1;
        ResultSrc = RES_ALUOUT;
        mem_write = 1'b1;
        if (MemReady) state_d = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_RD2;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        ResultSrc = RES_ALUOUT;
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA   = SRCA_RD1;
        ALUSrcB   = SRCB_RD2;
        alu_op    = ALUOP_SUB;
        ResultSrc = RES_ALUOUT;
        case (funct3)
          3'b000:  pc_write = Zero;
          3'b001:  pc_write = ~Zero;
          default: pc_write = 1'b0;
        endcase
        state_d = S_FETCH;
      end
      S_JAL: begin
        // PC takes the target from ALUOut while OldPC+4 is computed for rd
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALUOUT;
        pc_write  = 1'b1;
        state_d   = S_ALUWB;
      end
      S_LUIWB: begin
        ResultSrc = RES_IMMEXT;
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .op5         (op[5]),
    .funct3      (funct3),
    .funct7_5    (funct7[5]),
    .alu_control (ALUControl)
  );

  assign ImmSrc = imm_src_of(op);

  // Strobes are suppressed combinationally so nothing writes while in reset
  assign PCWrite  = pc_write  & RST_N;
  assign MemRead  = mem_read  & RST_N;
  assign MemWrite = mem_write & RST_N;
  assign IRWrite  = ir_write  & RST_N;
  assign RegWrite = reg_write & RST_N;
  assign Illegal  = illegal   & RST_N;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_controller
//  Purpose  : Self-checking bench: instruction-level reference model with
//             randomized instructions, MemReady stalls and Zero flag.
//  Revision : 1.0  initial release
// ============================================================================
module tb_multicycle_controller;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic [6:0] funct7 = 7'd0;
  logic       Zero = 1'b0;
  logic       MemReady = 1'b0;
  logic       PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite, Illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ALUControl, ImmSrc;

  multicycle_controller dut (
    .CLK(CLK), .RST_N(RST_N), .op(op), .funct3(funct3), .funct7(funct7),
    .Zero(Zero), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegWrite(RegWrite),
    .Illegal(Illegal)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       pcw, adr, mrd, mwr, irw;
    logic [1:0] rs, sa, sb;
    logic [2:0] alu, imm;
    logic       rw, ill;
  } exp_t;

  logic [18:0] outs;
  assign outs = {PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, ResultSrc,
                 ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegWrite, Illegal};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [18:0] got, input logic [18:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Instruction steps as the architecture describes them
  localparam int ST_F = 0, ST_D = 1, ST_ADR = 2, ST_RD = 3, ST_MWB = 4,
                 ST_WR = 5, ST_EX = 6, ST_AWB = 7, ST_BR = 8, ST_JAL = 9,
                 ST_LUI = 10;

  function automatic logic [2:0] imm_of(input logic [6:0] o);
    case (o)
      7'b0000011, 7'b0010011: return 3'b000;
      7'b0100011:             return 3'b001;
      7'b1100011:             return 3'b010;
      7'b1101111:             return 3'b011;
      7'b0110111:             return 3'b100;
      default:                return 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] fdec(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
    case (f3)
      3'b000:  return (o[5] && f7[5]) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // Ordered list of steps one instruction walks through
  function automatic int seq_len(input logic [6:0] o);
    case (o)
      7'b0000011: return 5;
      7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111: return 4;
      7'b1100011, 7'b0110111: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int seq_step(input logic [6:0] o, input int i);
    int s[5];
    s = '{ST_F, ST_D, ST_F, ST_F, ST_F};
    case (o)
      7'b0000011: s = '{ST_F, ST_D, ST_ADR, ST_RD, ST_MWB};
      7'b0100011: s = '{ST_F, ST_D, ST_ADR, ST_WR, ST_F};
      7'b0110011, 7'b0010011: s = '{ST_F, ST_D, ST_EX, ST_AWB, ST_F};
      7'b1100011: s = '{ST_F, ST_D, ST_BR, ST_F, ST_F};
      7'b1101111: s = '{ST_F, ST_D, ST_JAL, ST_AWB, ST_F};
      7'b0110111: s = '{ST_F, ST_D, ST_LUI, ST_F, ST_F};
      default:    s = '{ST_F, ST_D, ST_F, ST_F, ST_F};
    endcase
    return s[i];
  endfunction

  // Expected outputs for one step given the current inputs
  function automatic logic [18:0] model(input int st, input logic [6:0] o,
      input logic [2:0] f3, input logic [6:0] f7, input logic z, input logic mr);
    exp_t e;
    e = '0;
    e.imm = imm_of(o);
    case (st)
      ST_F:   begin e.mrd = 1; e.sb = 2'b10; e.rs = 2'b10; e.irw = mr; e.pcw = mr; end
      ST_D:   begin e.sa = 2'b01; e.sb = 2'b01; e.ill = (seq_len(o) == 2); end
      ST_ADR: begin e.sa = 2'b10; e.sb = 2'b01; end
      ST_RD:  begin e.adr = 1; e.mrd = 1; end
      ST_MWB: begin e.rs = 2'b01; e.rw = 1; end
      ST_WR:  begin e.adr = 1; e.mwr = 1; end
      ST_EX:  begin e.sa = 2'b10; e.sb = o[5] ? 2'b00 : 2'b01; e.alu = fdec(o, f3, f7); end
      ST_AWB: begin e.rw = 1; end
      ST_BR:  begin
        e.sa = 2'b10; e.alu = 3'b001;
        e.pcw = (f3 == 3'b000) ? z : ((f3 == 3'b001) ? !z : 1'b0);
      end
      ST_JAL: begin e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1; end
      ST_LUI: begin e.rs = 2'b11; e.rw = 1; end
      default: e = '0;
    endcase
    return e;
  endfunction

  // While in reset: no strobes, selects as in fetch
  function automatic logic [18:0] reset_vec(input logic [6:0] o);
    exp_t e;
    e = model(ST_F, o, 3'd0, 7'd0, 1'b0, 1'b0);
    e.mrd = 1'b0;
    return e;
  endfunction

  task automatic cyc(input int st, input logic [6:0] o, input logic [2:0] f3,
                     input logic [6:0] f7, input logic mr, input logic z);
    @(negedge CLK);
    op = o; funct3 = f3; funct7 = f7; MemReady = mr; Zero = z;
    #1;
    check($sformatf("op=%b f3=%b step=%0d mr=%b z=%b", o, f3, st, mr, z),
          outs, model(st, o, f3, f7, z, mr));
  endtask

  // fstall >= 0: fixed fetch wait count; rnd_mr: random memory stalls;
  // zf < 0: random Zero, else forced
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                           input int fstall, input bit rnd_mr, input int zf);
    int n;
    n = seq_len(o);
    for (int i = 0; i < n; i++) begin
      int st;
      int waits;
      logic mr, z;
      st = seq_step(o, i);
      waits = 0;
      do begin
        if (st == ST_F && fstall >= 0) mr = (waits >= fstall);
        else if (rnd_mr) mr = ($urandom_range(0, 3) != 0) || (waits > 8);
        else mr = 1'b1;
        if (st != ST_F && st != ST_RD && st != ST_WR) mr = 1'($urandom_range(0, 1));
        z = (zf < 0) ? 1'($urandom_range(0, 1)) : (zf != 0);
        cyc(st, o, f3, f7, mr, z);
        waits++;
      end while ((st == ST_F || st == ST_RD || st == ST_WR) && !mr);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] ops [7];
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
            7'b1100011, 7'b1101111, 7'b0110111};
    // Reset state, strobes gated even with MemReady high
    RST_N = 1'b0; op = 7'b0100011; MemReady = 1'b1;
    #3;
    check("reset_outputs", outs, reset_vec(op));
    @(negedge CLK);
    MemReady = 1'b0;
    RST_N = 1'b1;

    // Directed cases
    run_instr(7'b0000011, 3'b010, 7'd0, 0, 1'b0, -1);          // lw
    run_instr(7'b0000011, 3'b010, 7'd0, 3, 1'b0, -1);          // fetch stall
    run_instr(7'b1100011, 3'b000, 7'd0, 0, 1'b0, 1);           // beq taken
    run_instr(7'b1100011, 3'b001, 7'd0, 0, 1'b0, 1);           // bne not taken
    run_instr(7'b0110011, 3'b000, 7'b0100000, 0, 1'b0, -1);    // sub
    run_instr(7'b0010011, 3'b000, 7'b0100000, 0, 1'b0, -1);    // addi
    run_instr(7'b1111111, 3'b000, 7'd0, 0, 1'b0, -1);          // illegal
    run_instr(7'b1101111, 3'b000, 7'd0, 0, 1'b0, -1);          // jal
    run_instr(7'b0110111, 3'b000, 7'd0, 0, 1'b0, -1);          // lui

    // Reset while a store is waiting on memory
    cyc(ST_F,   7'b0100011, 3'b010, 7'd0, 1'b1, 1'b0);
    cyc(ST_D,   7'b0100011, 3'b010, 7'd0, 1'b1, 1'b0);
    cyc(ST_ADR, 7'b0100011, 3'b010, 7'd0, 1'b1, 1'b0);
    cyc(ST_WR,  7'b0100011, 3'b010, 7'd0, 1'b0, 1'b0);
    #1 RST_N = 1'b0;
    #1 check("reset_mid_store", outs, reset_vec(op));
    @(posedge CLK);
    #1 check("reset_held", outs, reset_vec(op));
    @(negedge CLK);
    MemReady = 1'b0;
    RST_N = 1'b1;
    cyc(ST_F, 7'b0100011, 3'b010, 7'd0, 1'b0, 1'b0);
    run_instr(7'b0100011, 3'b010, 7'd0, 1, 1'b0, -1);

    // Randomized instruction stream
    for (int k = 0; k < 400; k++) begin
      logic [6:0] o, f7;
      logic [2:0] f3;
      int sel;
      sel = $urandom_range(0, 8);
      o = (sel < 7) ? ops[sel] : 7'($urandom);
      f3 = 3'($urandom);
      case ($urandom_range(0, 2))
        0: f7 = 7'd0;
        1: f7 = 7'b0100000;
        default: f7 = 7'($urandom);
      endcase
      run_instr(o, f3, f7, -1, 1'b1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
